// File: rtl/download_sequencer_if.sv
// Bundle of the data_io ioctl stream, the memory write port and the loader status
// seen by the download sequencer.
interface download_sequencer_if #(
    parameter int ADDR_W = 25
);
    logic              clk_ena;
    logic              ioctl_download;
    logic [7:0]        ioctl_index;
    logic [ADDR_W-1:0] ioctl_addr;
    logic [7:0]        ioctl_dout;
    logic              ioctl_wr;
    logic              mem_ready;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
    logic              downloading;
    logic              rom_done;
    logic              prg_done;
    logic [ADDR_W-1:0] byte_count;

    // Source side: data_io plus the memory arbiter.
    modport master (
        output clk_ena, ioctl_download, ioctl_index, ioctl_addr, ioctl_dout, ioctl_wr, mem_ready,
        input  wr, addr, data, downloading, rom_done, prg_done, byte_count
    );

    // Sequencer side.
    modport slave (
        input  clk_ena, ioctl_download, ioctl_index, ioctl_addr, ioctl_dout, ioctl_wr, mem_ready,
        output wr, addr, data, downloading, rom_done, prg_done, byte_count
    );
endinterface

// File: rtl/download_sequencer.sv
// Download sequencer: maps data_io ROM/PRG streams into memory, then writes BASIC
// end-of-program pointers and holds the CPU through a settle period before release.
module download_sequencer #(
    parameter int ADDR_W         = 25,
    parameter int BOOT_INDEX     = 0,
    parameter int PRG_INDEX      = 2,
    parameter int ROM_INDEX      = 3,
    parameter int ROM_START_ADDR = 0,
    parameter int PRG_START_ADDR = 'h8241,
    parameter int PTR_BASE       = 'h8160,
    parameter int PTR_COUNT      = 1,
    parameter int PTR_BYTES      = 2,
    parameter int SETTLE_CYCLES  = 2
) (
    input  logic                clk,
    input  logic                reset,
    download_sequencer_if.slave bus,
    output logic [2:0]          state_dbg
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COPY    = 3'd1,
        PTR     = 3'd2,
        SETTLE  = 3'd3,
        RELEASE = 3'd4
    } state_t;

    typedef enum logic [1:0] {CLS_ROM, CLS_PRG, CLS_OTHER} cls_t;

    localparam int IDX_W = 5;
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [31:0] END_MASK =
        (PTR_BYTES >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * PTR_BYTES)) - 32'd1);

    state_t            state;
    cls_t              cls;
    cls_t              new_cls;
    logic [31:0]       end_value;
    logic [IDX_W-1:0]  ptr_idx;
    logic [1:0]        ptr_b;
    logic [1:0]        b_next;
    logic              ptr_last;
    logic [CNT_W-1:0]  settle_cnt;
    logic [ADDR_W-1:0] next_len;
    logic [31:0]       end_sum;
    logic              abort;

    function automatic logic [ADDR_W-1:0] ptr_addr_of(input logic [IDX_W-1:0] i);
        return ADDR_W'(PTR_BASE) + ADDR_W'(i);
    endfunction

    function automatic logic [7:0] ptr_byte(input logic [31:0] v, input logic [1:0] b);
        return v[{b, 3'b000} +: 8];
    endfunction

    always_comb begin
        new_cls = CLS_OTHER;
        if (bus.ioctl_index == 8'(BOOT_INDEX) || bus.ioctl_index == 8'(ROM_INDEX))
            new_cls = CLS_ROM;
        else if (bus.ioctl_index == 8'(PRG_INDEX))
            new_cls = CLS_PRG;
    end

    assign next_len  = bus.ioctl_addr + ADDR_W'(1);
    assign end_sum   = (32'(PRG_START_ADDR) + 32'(bus.byte_count)) & END_MASK;
    assign b_next    = (ptr_b == 2'(PTR_BYTES - 1)) ? 2'd0 : ptr_b + 2'd1;
    assign ptr_last  = (ptr_idx == IDX_W'(PTR_COUNT * PTR_BYTES - 1));
    // A new download may start at any point of the post-load sequence.
    assign abort     = bus.ioctl_download && (state == PTR || state == SETTLE || state == RELEASE);
    assign state_dbg = state;

    // Pointer-write handshake: while wr=1 the sequencer holds addr/data stable; a byte
    // is transferred in a cycle where wr=1 and mem_ready=1, and the next byte (or
    // wr=0 after the last one) appears the following cycle. mem_ready is don't-care
    // whenever wr=0 and during file copy.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            cls             <= CLS_OTHER;
            end_value       <= '0;
            ptr_idx         <= '0;
            ptr_b           <= '0;
            settle_cnt      <= '0;
            bus.wr          <= 1'b0;
            bus.addr        <= '0;
            bus.data        <= '0;
            bus.downloading <= 1'b0;
            bus.rom_done    <= 1'b0;
            bus.prg_done    <= 1'b0;
            bus.byte_count  <= '0;
        end else begin
            bus.prg_done <= 1'b0;
            if (abort) begin
                state           <= COPY;
                cls             <= new_cls;
                bus.wr          <= 1'b0;
                bus.downloading <= 1'b1;
                bus.byte_count  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.ioctl_download) begin
                            state           <= COPY;
                            cls             <= new_cls;
                            bus.downloading <= 1'b1;
                            bus.byte_count  <= '0;
                        end
                    end
                    COPY: begin
                        if (bus.ioctl_download) begin
                            bus.data <= bus.ioctl_dout;
                            bus.wr   <= bus.ioctl_wr && (cls != CLS_OTHER);
                            case (cls)
                                CLS_ROM: bus.addr <= ADDR_W'(ROM_START_ADDR) + bus.ioctl_addr;
                                CLS_PRG: bus.addr <= ADDR_W'(PRG_START_ADDR) + bus.ioctl_addr;
                                default: bus.addr <= bus.ioctl_addr;
                            endcase
                            if (bus.ioctl_wr && next_len > bus.byte_count)
                                bus.byte_count <= next_len;
                        end else begin
                            bus.wr     <= 1'b0;
                            end_value  <= end_sum;
                            ptr_idx    <= '0;
                            ptr_b      <= '0;
                            settle_cnt <= '0;
                            if (cls == CLS_PRG) begin
                                state <= PTR;
                            end else begin
                                state <= SETTLE;
                                if (cls == CLS_ROM) bus.rom_done <= 1'b1;
                            end
                        end
                    end
                    PTR: begin
                        if (!bus.wr) begin
                            bus.wr   <= 1'b1;
                            bus.addr <= ptr_addr_of(ptr_idx);
                            bus.data <= ptr_byte(end_value, ptr_b);
                        end else if (bus.mem_ready) begin
                            if (ptr_last) begin
                                bus.wr     <= 1'b0;
                                settle_cnt <= '0;
                                state      <= SETTLE;
                            end else begin
                                ptr_idx  <= ptr_idx + IDX_W'(1);
                                ptr_b    <= b_next;
                                bus.addr <= ptr_addr_of(ptr_idx + IDX_W'(1));
                                bus.data <= ptr_byte(end_value, b_next);
                            end
                        end
                    end
                    SETTLE: begin
                        if (settle_cnt == CNT_W'(SETTLE_CYCLES - 1))
                            state <= RELEASE;
                        else
                            settle_cnt <= settle_cnt + CNT_W'(1);
                    end
                    RELEASE: begin
                        bus.downloading <= 1'b0;
                        if (cls == CLS_PRG) bus.prg_done <= 1'b1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_download_sequencer.sv
// Directed bench for download_sequencer: memory writes are checked against an
// expected queue, status and FSM state against fixed expectations.
module tb_download_sequencer;
    localparam int ADDR_W = 25;
    localparam logic [2:0] S_IDLE = 3'd0, S_COPY = 3'd1, S_PTR = 3'd2,
                           S_SETTLE = 3'd3, S_RELEASE = 3'd4;

    logic              clk = 1'b0;
    logic              reset;
    logic              dl, iwr, mrdy;
    logic [7:0]        idx, dout;
    logic [ADDR_W-1:0] ia;
    logic [2:0]        state_a, state_b;
    int                total = 0;
    int                bad = 0;
    int                prg_pulses = 0;
    int                pulses_before;
    logic              mon_b = 1'b0;
    logic [ADDR_W+7:0] exp_q[$];
    logic [ADDR_W+7:0] exp_b[$];
    logic [7:0]        rom_vals[4];

    always #5 clk = ~clk;

    download_sequencer_if #(.ADDR_W(ADDR_W)) ifa ();
    download_sequencer_if #(.ADDR_W(ADDR_W)) ifb ();

    assign ifa.clk_ena = 1'b1;
    assign ifa.ioctl_download = dl;
    assign ifa.ioctl_index = idx;
    assign ifa.ioctl_addr = ia;
    assign ifa.ioctl_dout = dout;
    assign ifa.ioctl_wr = iwr;
    assign ifa.mem_ready = mrdy;
    assign ifb.clk_ena = 1'b1;
    assign ifb.ioctl_download = dl;
    assign ifb.ioctl_index = idx;
    assign ifb.ioctl_addr = ia;
    assign ifb.ioctl_dout = dout;
    assign ifb.ioctl_wr = iwr;
    assign ifb.mem_ready = mrdy;

    download_sequencer dut_a (.clk(clk), .reset(reset), .bus(ifa), .state_dbg(state_a));
    download_sequencer #(.PTR_COUNT(3)) dut_b (.clk(clk), .reset(reset), .bus(ifb), .state_dbg(state_b));

    // Scoreboard: every write strobe must match the queue head; it retires on acceptance.
    always @(negedge clk) begin
        if (!reset && ifa.wr) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $error("FAIL a_unexpected_wr observed=%h/%h expected=none", ifa.addr, ifa.data);
            end else begin
                assert ({ifa.addr, ifa.data} === exp_q[0]) else begin
                    bad++;
                    $error("FAIL a_write observed=%h expected=%h", {ifa.addr, ifa.data}, exp_q[0]);
                end
                if (ifa.mem_ready) void'(exp_q.pop_front());
            end
        end
        if (mon_b && !reset && ifb.wr) begin
            total++;
            if (exp_b.size() == 0) begin
                bad++;
                $error("FAIL b_unexpected_wr observed=%h/%h expected=none", ifb.addr, ifb.data);
            end else begin
                assert ({ifb.addr, ifb.data} === exp_b[0]) else begin
                    bad++;
                    $error("FAIL b_write observed=%h expected=%h", {ifb.addr, ifb.data}, exp_b[0]);
                end
                if (ifb.mem_ready) void'(exp_b.pop_front());
            end
        end
        if (ifa.prg_done) prg_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [ADDR_W-1:0] off, input logic [7:0] val,
                             input logic [ADDR_W-1:0] base, input logic expect_wr);
        step();
        iwr = 1'b1;
        ia = off;
        dout = val;
        if (expect_wr) exp_q.push_back({base + off, val});
        step();
        iwr = 1'b0;
        check("wr_latency", 32'(ifa.wr), 32'(expect_wr));
    endtask

    task automatic wait_state(input logic [2:0] s, input int limit, input string tag);
        int n = 0;
        while (state_a !== s && n < limit) begin
            step();
            n++;
        end
        check(tag, 32'(state_a), 32'(s));
    endtask

    task automatic wait_wr(input int limit, input string tag);
        int n = 0;
        while (ifa.wr !== 1'b1 && n < limit) begin
            step();
            n++;
        end
        check(tag, 32'(ifa.wr), 32'd1);
    endtask

    task automatic finish_seq(input logic exp_prg, input logic exp_rom, input string tag);
        wait_state(S_SETTLE, 40, {tag, "_settle1"});
        check({tag, "_rom_done"}, 32'(ifa.rom_done), 32'(exp_rom));
        check({tag, "_dl_hold"}, 32'(ifa.downloading), 32'd1);
        check({tag, "_settle_wr"}, 32'(ifa.wr), 32'd0);
        step();
        check({tag, "_settle2"}, 32'(state_a), 32'(S_SETTLE));
        step();
        check({tag, "_release"}, 32'(state_a), 32'(S_RELEASE));
        check({tag, "_rel_dl"}, 32'(ifa.downloading), 32'd1);
        step();
        check({tag, "_idle"}, 32'(state_a), 32'(S_IDLE));
        check({tag, "_dl_low"}, 32'(ifa.downloading), 32'd0);
        check({tag, "_prg_done"}, 32'(ifa.prg_done), 32'(exp_prg));
        step();
        check({tag, "_prg_done_end"}, 32'(ifa.prg_done), 32'd0);
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        dl = 1'b0;
        iwr = 1'b0;
        mrdy = 1'b1;
        idx = 8'd0;
        dout = 8'd0;
        ia = '0;
        rom_vals = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        repeat (3) step();
        check("rst_wr", 32'(ifa.wr), 32'd0);
        check("rst_addr", 32'(ifa.addr), 32'd0);
        check("rst_data", 32'(ifa.data), 32'd0);
        check("rst_dl", 32'(ifa.downloading), 32'd0);
        check("rst_rom_done", 32'(ifa.rom_done), 32'd0);
        check("rst_prg_done", 32'(ifa.prg_done), 32'd0);
        check("rst_count", 32'(ifa.byte_count), 32'd0);
        check("rst_state", 32'(state_a), 32'(S_IDLE));
        reset = 1'b0;

        // Index 5: data discarded, no status bits.
        step();
        idx = 8'd5;
        dl = 1'b1;
        for (int i = 0; i < 8; i++)
            send_byte(ADDR_W'(i), 8'($urandom_range(0, 255)), '0, 1'b0);
        step();
        dl = 1'b0;
        finish_seq(1'b0, 1'b0, "other");
        check("other_count", 32'(ifa.byte_count), 32'd8);

        // PRG of 16 bytes, memory always ready.
        step();
        idx = 8'd2;
        dl = 1'b1;
        for (int i = 0; i < 16; i++)
            send_byte(ADDR_W'(i), 8'($urandom_range(0, 255)), ADDR_W'('h8241), 1'b1);
        exp_q.push_back({25'h8160, 8'h51});
        exp_q.push_back({25'h8161, 8'h82});
        step();
        dl = 1'b0;
        finish_seq(1'b1, 1'b0, "prg");
        check("prg_count", 32'(ifa.byte_count), 32'd16);

        // Same PRG sent in reverse order, first pointer byte stalled three cycles.
        step();
        idx = 8'd2;
        dl = 1'b1;
        for (int i = 15; i >= 0; i--)
            send_byte(ADDR_W'(i), 8'($urandom_range(0, 255)), ADDR_W'('h8241), 1'b1);
        exp_q.push_back({25'h8160, 8'h51});
        exp_q.push_back({25'h8161, 8'h82});
        step();
        dl = 1'b0;
        mrdy = 1'b0;
        wait_wr(20, "stall_wr_seen");
        check("stall_addr1", 32'(ifa.addr), 32'h8160);
        check("stall_data1", 32'(ifa.data), 32'h51);
        step();
        check("stall_addr2", 32'(ifa.addr), 32'h8160);
        check("stall_wr2", 32'(ifa.wr), 32'd1);
        step();
        check("stall_addr3", 32'(ifa.addr), 32'h8160);
        check("stall_wr3", 32'(ifa.wr), 32'd1);
        step();
        mrdy = 1'b1;
        check("stall_addr4", 32'(ifa.addr), 32'h8160);
        check("stall_data4", 32'(ifa.data), 32'h51);
        step();
        check("stall_next_addr", 32'(ifa.addr), 32'h8161);
        check("stall_next_data", 32'(ifa.data), 32'h82);
        finish_seq(1'b1, 1'b0, "stall");
        check("stall_count", 32'(ifa.byte_count), 32'd16);

        // Zero-length PRG; the three-pointer instance writes six bytes.
        mon_b = 1'b1;
        step();
        idx = 8'd2;
        dl = 1'b1;
        exp_q.push_back({25'h8160, 8'h41});
        exp_q.push_back({25'h8161, 8'h82});
        for (int w = 0; w < 3; w++) begin
            exp_b.push_back({ADDR_W'('h8160 + 2 * w), 8'h41});
            exp_b.push_back({ADDR_W'('h8161 + 2 * w), 8'h82});
        end
        step();
        step();
        dl = 1'b0;
        finish_seq(1'b1, 1'b0, "zero");
        repeat (6) step();
        check("zero_b_queue", 32'(exp_b.size()), 32'd0);
        check("zero_b_state", 32'(state_b), 32'(S_IDLE));
        check("zero_count", 32'(ifa.byte_count), 32'd0);
        mon_b = 1'b0;

        // ROM image at index 0.
        step();
        idx = 8'd0;
        dl = 1'b1;
        for (int i = 0; i < 4; i++)
            send_byte(ADDR_W'(i), rom_vals[i], '0, 1'b1);
        step();
        dl = 1'b0;
        finish_seq(1'b0, 1'b1, "rom");
        check("rom_count", 32'(ifa.byte_count), 32'd4);

        // PRG aborted by a new download during settle: no prg_done, rom_done kept.
        step();
        idx = 8'd2;
        dl = 1'b1;
        send_byte('0, 8'h11, ADDR_W'('h8241), 1'b1);
        send_byte(ADDR_W'(1), 8'h22, ADDR_W'('h8241), 1'b1);
        exp_q.push_back({25'h8160, 8'h43});
        exp_q.push_back({25'h8161, 8'h82});
        pulses_before = prg_pulses;
        step();
        dl = 1'b0;
        wait_state(S_SETTLE, 20, "redl_settle");
        idx = 8'd5;
        dl = 1'b1;
        step();
        check("redl_copy", 32'(state_a), 32'(S_COPY));
        check("redl_wr", 32'(ifa.wr), 32'd0);
        check("redl_dl", 32'(ifa.downloading), 32'd1);
        send_byte('0, 8'h33, '0, 1'b0);
        step();
        dl = 1'b0;
        finish_seq(1'b0, 1'b1, "redl");
        check("redl_prg_pulses", 32'(prg_pulses), 32'(pulses_before));

        // Reset in the middle of the pointer write.
        step();
        idx = 8'd2;
        dl = 1'b1;
        send_byte('0, 8'h5A, ADDR_W'('h8241), 1'b1);
        exp_q.push_back({25'h8160, 8'h42});
        exp_q.push_back({25'h8161, 8'h82});
        step();
        dl = 1'b0;
        mrdy = 1'b0;
        wait_wr(20, "ptrrst_wr_seen");
        check("ptrrst_addr1", 32'(ifa.addr), 32'h8160);
        mrdy = 1'b1;
        step();
        mrdy = 1'b0;
        check("ptrrst_addr2", 32'(ifa.addr), 32'h8161);
        check("ptrrst_state", 32'(state_a), 32'(S_PTR));
        reset = 1'b1;
        step();
        check("ptrrst_wr", 32'(ifa.wr), 32'd0);
        check("ptrrst_addr", 32'(ifa.addr), 32'd0);
        check("ptrrst_data", 32'(ifa.data), 32'd0);
        check("ptrrst_dl", 32'(ifa.downloading), 32'd0);
        check("ptrrst_rom_done", 32'(ifa.rom_done), 32'd0);
        check("ptrrst_prg_done", 32'(ifa.prg_done), 32'd0);
        check("ptrrst_count", 32'(ifa.byte_count), 32'd0);
        check("ptrrst_idle", 32'(state_a), 32'(S_IDLE));
        reset = 1'b0;
        exp_q.delete();
        mrdy = 1'b1;
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/download_sequencer.md
Name: download_sequencer

Overview:
- Parametrised successor to the SPI download path.
- Consumes the data_io ioctl stream and maps ROM and PRG files into the target address space.
- After a PRG load, writes a configurable set of little-endian BASIC end-of-program pointers, then holds the CPU through a configurable settle period.
- Sits between data_io and the RAM/ROM arbiter. It adds a memory-ready handshake for pointer writes and true file-length tracking.

Parameters:
ADDR_W, 25, width of ioctl_addr and addr
BOOT_INDEX, 0, ioctl_index of boot ROM image
PRG_INDEX, 2, ioctl_index of BASIC program file
ROM_INDEX, 3, ioctl_index of user ROM image
ROM_START_ADDR, 0, base address for ROM downloads
PRG_START_ADDR, 'h8241, base address for PRG downloads
PTR_BASE, 'h8160, address of first pointer word
PTR_COUNT, 1, number of consecutive pointer words written after PRG (1..4)
PTR_BYTES, 2, bytes per pointer word (1..4), little-endian
SETTLE_CYCLES, 2, cycles with wr=0 and downloading=1 before release (>=1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
clk_ena  in  1  data_io clock reference enable
ioctl_download  in  1  data_io download active
ioctl_index  in  8  file index
ioctl_addr  in  ADDR_W  byte offset within file
ioctl_dout  in  8  file byte
ioctl_wr  in  1  byte strobe
mem_ready  in  1  memory accepted current pointer write
wr  out  1  memory write strobe
addr  out  ADDR_W  memory address
data  out  8  memory write data
downloading  out  1  hold CPU / give bus to loader
rom_done  out  1  sticky: a ROM/BOOT download completed
prg_done  out  1  one-cycle pulse at release after a PRG load
byte_count  out  ADDR_W  bytes received in current/last download

Behaviour:
- Reset values: wr=0, addr=0, data=0, downloading=0, rom_done=0, prg_done=0, byte_count=0, state=IDLE. Reset overrides everything, including mid-download and mid-pointer-write.
- Index class is latched at the rising edge of ioctl_download: ROM (BOOT_INDEX or ROM_INDEX), PRG (PRG_INDEX), or OTHER.
- IDLE: ioctl_download=1 -> COPY. In that same cycle downloading<=1 and byte_count<=0.
- COPY, per cycle with 1-cycle registered latency:
  - data<=ioctl_dout.
  - addr<=ROM_START_ADDR+ioctl_addr for ROM, PRG_START_ADDR+ioctl_addr for PRG; sums truncated to ADDR_W.
  - wr<=ioctl_wr for ROM/PRG; wr<=0 for OTHER (data discarded).
  - On each ioctl_wr: byte_count<=max(byte_count, ioctl_addr+1). Out-of-order bytes never shrink the length.
  - mem_ready is ignored in COPY.
- Falling edge of ioctl_download in COPY:
  - wr<=0 that cycle.
  - PRG -> PTR; ROM/OTHER -> SETTLE.
  - end_value=PRG_START_ADDR+byte_count is latched and truncated to PTR_BYTES*8. It points to the byte after the program; a zero-length PRG gives PRG_START_ADDR.
- PTR: iterates word w=0..PTR_COUNT-1 and byte b=0..PTR_BYTES-1.
  - addr=PTR_BASE+w*PTR_BYTES+b, data=end_value[8b+7:8b], wr=1.
  - wr, addr and data stay stable until a cycle with wr=1 and mem_ready=1; the next byte is presented the cycle after.
  - After the last byte is accepted: wr<=0 -> SETTLE.
- SETTLE: wr=0, downloading=1 for exactly SETTLE_CYCLES cycles -> RELEASE.
  - rom_done<=1 on entry if class=ROM.
- RELEASE, one cycle: downloading<=0, prg_done<=1 if class=PRG, -> IDLE.
- ioctl_download re-asserted in PTR, SETTLE or RELEASE:
  - Abort the sequence and go to COPY next cycle, with wr=0 in the abort cycle.
  - No prg_done. rom_done is kept only if already set.
- rom_done is cleared only by reset.

Test Plan:
- ROM index 0, 4 bytes at offsets 0..3 (AA,BB,CC,DD) -> wr pulses at addr ROM_START_ADDR+0..3 one cycle after each ioctl_wr. SETTLE lasts 2 cycles, downloading falls after it, rom_done=1, no pointer writes.
- PRG index 2, 0x10 bytes, PTR_COUNT=1, PTR_BYTES=2, mem_ready=1 -> data at 'h8241..'h8250, then writes 'h8160<='51, 'h8161<='82, then 2 settle cycles, prg_done pulse, byte_count=16.
- Same PRG with mem_ready low for 3 cycles on first pointer byte -> wr/addr/data held stable 4 cycles; second byte follows only after acceptance.
- PTR_COUNT=3, PTR_BYTES=2, zero-length PRG -> six writes 'h8160..'h8165 = 41,82,41,82,41,82.
- Index 5 download of 8 bytes -> no wr pulses, downloading asserted then released, rom_done stays 0, no prg_done.
- Reset asserted during PTR after first byte -> next cycle all outputs at reset values. Re-download during SETTLE -> returns to COPY, no prg_done.
